// File: rtl/dac_sweep_sequencer.sv
// dac_sweep_sequencer
// Top-level scheduler for a DAC step / ADC read sweep. For each of N_STEPS
// steps it issues a DAC SPI write, waits SETTLE_CYC cycles, issues an ADC
// read, then a UART transmit of the result. Peripheral start strobes are
// driven from their end-of-operation flags.
//
// Ports
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   start_i     level, sampled in IDLE/DONE, starts a sweep from step 0
//   abort_i     level, returns to IDLE at the next edge (step/code held)
//   dac_eow_i   DAC writer end-of-write (1 = idle, 0 = busy)
//   adc_eor_i   ADC reader end-of-read  (1 = idle, 0 = busy)
//   tx_done_i   UART TX one-cycle done pulse
//   dac_strw_o  one-cycle DAC write start pulse
//   adc_strr_o  one-cycle ADC read start pulse
//   tx_start_o  one-cycle UART send pulse
//   dac_code_o  code presented to the DAC, stable for the whole step
//   step_o      current step index
//   busy_o      high in every state except IDLE and DONE
//   done_o      high while in DONE
module dac_sweep_sequencer #(
    parameter int N_STEPS    = 31,
    parameter int DATA_W     = 12,
    parameter int CODE_START = 0,
    parameter int CODE_INC   = 128,
    parameter int SETTLE_CYC = 1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              dac_eow_i,
    input  logic              adc_eor_i,
    input  logic              tx_done_i,
    output logic              dac_strw_o,
    output logic              adc_strr_o,
    output logic              tx_start_o,
    output logic [DATA_W-1:0] dac_code_o,
    output logic [7:0]        step_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int MAX_CODE  = (1 << DATA_W) - 1;
    localparam int START_SAT = (CODE_START > MAX_CODE) ? MAX_CODE : CODE_START;
    // Clamping the increment to full scale keeps it within DATA_W+1 bits while
    // still saturating exactly as the unclamped sum would.
    localparam int INC_SAT   = (CODE_INC > MAX_CODE) ? MAX_CODE : CODE_INC;
    localparam int CNT_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [DATA_W-1:0] CODE_INIT  = DATA_W'(START_SAT);
    localparam logic [DATA_W:0]   INC_W      = (DATA_W+1)'(INC_SAT);
    localparam logic [DATA_W:0]   CODE_MAX_W = (DATA_W+1)'(MAX_CODE);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SETTLE_CYC - 1);
    localparam logic [7:0]        LAST_STEP  = 8'(N_STEPS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DAC_REQ,
        S_DAC_WBUSY,
        S_DAC_WDONE,
        S_SETTLE,
        S_ADC_REQ,
        S_ADC_WBUSY,
        S_ADC_WDONE,
        S_TX_REQ,
        S_TX_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        step_q, step_d;
    logic [DATA_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W:0]   code_sum;
    logic              dac_strw_d, adc_strr_d, tx_start_d, busy_d, done_d;

    assign dac_code_o = code_q;
    assign step_o     = step_q;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        code_sum = {1'b0, code_q} + INC_W;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    step_d  = 8'd0;
                    code_d  = CODE_INIT;
                    state_d = S_DAC_REQ;
                end
            end
            S_DAC_REQ:   state_d = S_DAC_WBUSY;
            // eow idles high, so first see it drop before waiting for the rise
            S_DAC_WBUSY: if (!dac_eow_i) state_d = S_DAC_WDONE;
            S_DAC_WDONE: begin
                if (dac_eow_i) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) state_d = S_ADC_REQ;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_ADC_REQ:   state_d = S_ADC_WBUSY;
            S_ADC_WBUSY: if (!adc_eor_i) state_d = S_ADC_WDONE;
            S_ADC_WDONE: if (adc_eor_i)  state_d = S_TX_REQ;
            S_TX_REQ:    state_d = S_TX_WAIT;
            // A done pulse coincident with our own start pulse cannot belong
            // to this transmit, so it is ignored.
            S_TX_WAIT:   if (tx_done_i && !tx_start_o) state_d = S_NEXT;
            S_NEXT: begin
                if (step_q == LAST_STEP) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + 8'd1;
                    code_d  = (code_sum > CODE_MAX_W) ? CODE_MAX_W[DATA_W-1:0]
                                                      : code_sum[DATA_W-1:0];
                    state_d = S_DAC_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any transition; step and code keep their values.
        if (abort_i) begin
            state_d = S_IDLE;
            step_d  = step_q;
            code_d  = code_q;
        end

        // Strobes follow the request state by one registered cycle;
        // busy/done track the state being entered so they align with it.
        dac_strw_d = (state_q == S_DAC_REQ) && !abort_i;
        adc_strr_d = (state_q == S_ADC_REQ) && !abort_i;
        tx_start_d = (state_q == S_TX_REQ)  && !abort_i;
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            step_q     <= 8'd0;
            code_q     <= '0;
            cnt_q      <= '0;
            dac_strw_o <= 1'b0;
            adc_strr_o <= 1'b0;
            tx_start_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            dac_strw_o <= dac_strw_d;
            adc_strr_o <= adc_strr_d;
            tx_start_o <= tx_start_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
        end
    end

endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// Bench for dac_sweep_sequencer. Two instances share every input: one sweeps
// from code 0, the other from 4000 so its codes saturate. Peripheral models
// with random busy lengths answer the strobes; a scoreboard checks codes,
// step order and cycle latencies derived from the sweep rules.
module tb_dac_sweep_sequencer;
    localparam int N       = 3;
    localparam int DW      = 12;
    localparam int INC     = 100;
    localparam int S       = 4;
    localparam int START_A = 0;
    localparam int START_B = 4000;

    logic clk_i = 1'b0;
    logic rst_i, start_i, abort_i, dac_eow_i, adc_eor_i, tx_done_i;
    logic a_dac_strw, a_adc_strr, a_tx_start, a_busy, a_done;
    logic b_dac_strw, b_adc_strr, b_tx_start, b_busy, b_done;
    logic [DW-1:0] a_code, b_code;
    logic [7:0]    a_step, b_step;

    always #5 clk_i = ~clk_i;

    dac_sweep_sequencer #(.N_STEPS(N), .DATA_W(DW), .CODE_START(START_A),
                          .CODE_INC(INC), .SETTLE_CYC(S)) u_dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .dac_eow_i(dac_eow_i), .adc_eor_i(adc_eor_i), .tx_done_i(tx_done_i),
        .dac_strw_o(a_dac_strw), .adc_strr_o(a_adc_strr), .tx_start_o(a_tx_start),
        .dac_code_o(a_code), .step_o(a_step), .busy_o(a_busy), .done_o(a_done));

    dac_sweep_sequencer #(.N_STEPS(N), .DATA_W(DW), .CODE_START(START_B),
                          .CODE_INC(INC), .SETTLE_CYC(S)) u_dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .dac_eow_i(dac_eow_i), .adc_eor_i(adc_eor_i), .tx_done_i(tx_done_i),
        .dac_strw_o(b_dac_strw), .adc_strr_o(b_adc_strr), .tx_start_o(b_tx_start),
        .dac_code_o(b_code), .step_o(b_step), .busy_o(b_busy), .done_o(b_done));

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int dac_pre = 0, dac_busy = 0, adc_busy = 0, tx_cnt = 0;
    int pre_hold = 0;
    bit inject = 0;
    int n_dac = 0, n_adc = 0, n_tx = 0, n_strobes = 0;
    int start_tick = 0, eow_rise_tick = 0, txdone_tick = 0;
    bit prev_done = 0, prev_dac = 0, prev_adc = 0, prev_tx = 0;

    // Expected code at step k: linear ramp clipped at full scale.
    function automatic int exp_code(input int base, input int k);
        int v;
        v = base + k * INC;
        return (v > (1 << DW) - 1) ? (1 << DW) - 1 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic new_sweep();
        n_dac = 0; n_adc = 0; n_tx = 0;
        start_tick = cyc;
    endtask

    // One clock: sample outputs after the edge, score them, then let the
    // peripheral models set up inputs for the next edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        if (a_dac_strw) begin
            n_strobes++;
            chk("dac_pulse_width", 32'(prev_dac), 0);
            if (n_dac == 0) chk("start_to_dac_lat", cyc - start_tick, 2);
            else            chk("txdone_to_dac_lat", cyc - txdone_tick, 3);
            chk("dac_step", a_step, n_dac);
            chk("dac_code", a_code, exp_code(START_A, n_dac));
            chk("dac_code_sat", b_code, exp_code(START_B, n_dac));
            chk("b_dac_step", b_step, n_dac);
            chk("b_dac_strw", b_dac_strw, 1);
            chk("busy_at_dac", a_busy, 1);
            chk("b_busy_at_dac", b_busy, 1);
            n_dac++;
        end
        if (a_adc_strr) begin
            n_strobes++;
            chk("adc_pulse_width", 32'(prev_adc), 0);
            // edges from the one sampling dac_eow_i high to the adc strobe
            chk("settle_lat", cyc - eow_rise_tick - 1, S + 1);
            chk("adc_order", n_adc + 1, n_dac);
            chk("b_adc_strr", b_adc_strr, 1);
            n_adc++;
        end
        if (a_tx_start) begin
            n_strobes++;
            chk("tx_pulse_width", 32'(prev_tx), 0);
            chk("tx_order", n_tx + 1, n_adc);
            chk("b_tx_start", b_tx_start, 1);
            n_tx++;
        end
        if (a_done && !prev_done) begin
            chk("done_lat", cyc - txdone_tick, 2);
            chk("done_dac_cnt", n_dac, N);
            chk("done_adc_cnt", n_adc, N);
            chk("done_tx_cnt", n_tx, N);
            chk("done_step", a_step, N - 1);
            chk("done_code", a_code, exp_code(START_A, N - 1));
            chk("done_code_sat", b_code, exp_code(START_B, N - 1));
            chk("done_busy", a_busy, 0);
            chk("b_done", b_done, 1);
        end
        if (a_done && start_i) new_sweep();
        prev_done = a_done; prev_dac = a_dac_strw;
        prev_adc = a_adc_strr; prev_tx = a_tx_start;

        // DAC writer: optional idle-high hold, then a busy window
        if (a_dac_strw) begin
            dac_pre  = pre_hold;
            dac_busy = int'($urandom_range(1, 6));
        end
        if (dac_pre > 0) begin
            dac_eow_i = 1'b1; dac_pre--;
        end else if (dac_busy > 0) begin
            dac_eow_i = 1'b0; dac_busy--;
        end else begin
            if (!dac_eow_i) eow_rise_tick = cyc;
            dac_eow_i = 1'b1;
        end
        // ADC reader
        if (a_adc_strr) adc_busy = int'($urandom_range(1, 6));
        if (adc_busy > 0) begin
            adc_eor_i = 1'b0; adc_busy--;
        end else begin
            adc_eor_i = 1'b1;
        end
        // UART: optional stray pulse alongside tx_start_o, real one later
        tx_done_i = 1'b0;
        if (a_tx_start) begin
            tx_cnt = int'($urandom_range(1, 5));
            if (inject) tx_done_i = 1'b1;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done_i = 1'b1;
                txdone_tick = cyc;
            end
        end
    endtask

    task automatic run_until_done(input int budget);
        int k;
        k = 0;
        while (!a_done && k < budget) begin
            tick();
            k++;
        end
        chk("sweep_completes", a_done, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dac_strw"}, a_dac_strw, 0);
        chk({tag, "_adc_strr"}, a_adc_strr, 0);
        chk({tag, "_tx_start"}, a_tx_start, 0);
        chk({tag, "_code"}, a_code, 0);
        chk({tag, "_code_b"}, b_code, 0);
        chk({tag, "_step"}, a_step, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_done"}, a_done, 0);
    endtask

    initial begin
        int k, t_dac, n0, d;
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        dac_eow_i = 1'b1; adc_eor_i = 1'b1; tx_done_i = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // Randomised sweeps; sweep 1 holds eow idle-high for 10 cycles after
        // the write strobe, sweep 2 always injects a stray tx_done_i.
        for (int r = 0; r < 4; r++) begin
            pre_hold = (r == 1) ? 10 : int'($urandom_range(0, 3));
            inject   = (r == 2) || ($urandom_range(0, 1) == 1);
            repeat (int'($urandom_range(1, 5))) tick();
            new_sweep();
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            run_until_done(600);
            repeat (2) tick();
            chk("done_holds", a_done, 1);
        end

        // Abort while settling at step 1
        pre_hold = 0; inject = 0;
        new_sweep();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        k = 0;
        while (n_dac < 2 && k < 300) begin tick(); k++; end
        chk("abort_reach_step1", n_dac, 2);
        t_dac = cyc;
        k = 0;
        while (eow_rise_tick <= t_dac && k < 50) begin tick(); k++; end
        chk("abort_eow_seen", 32'(eow_rise_tick > t_dac), 1);
        tick();               // now in SETTLE
        abort_i = 1'b1;
        tick();
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        chk("abort_step", a_step, 1);
        chk("abort_code", a_code, exp_code(START_A, 1));
        chk("abort_code_sat", b_code, exp_code(START_B, 1));
        abort_i = 1'b0;
        n0 = n_strobes;
        repeat (20) tick();
        chk("abort_no_strobes", n_strobes - n0, 0);
        chk("abort_stays_idle", a_busy, 0);

        // Reset while waiting for the UART
        new_sweep();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        k = 0;
        while (n_tx < 1 && k < 300) begin tick(); k++; end
        chk("rst_reach_tx_wait", n_tx, 1);
        rst_i = 1'b1;
        tick();
        check_all_zero("midrst");
        rst_i = 1'b0;
        n0 = n_strobes;
        repeat (15) tick();
        chk("midrst_no_strobes", n_strobes - n0, 0);
        chk("midrst_idle", a_busy, 0);

        // start_i held high across DONE: back-to-back sweeps
        new_sweep();
        start_i = 1'b1;
        run_until_done(600);
        d = cyc;
        tick();
        chk("done_single_cycle", a_done, 0);
        chk("restart_step", a_step, 0);
        chk("restart_code", a_code, exp_code(START_A, 0));
        tick();
        chk("restart_strobe", a_dac_strw, 1);
        chk("restart_lat", cyc - d, 2);
        start_i = 1'b0;
        run_until_done(600);
        tick();
        chk("second_done_holds", a_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dac_sweep_sequencer.md
Name: dac_sweep_sequencer

Overview:
Top-level scheduler for the DAC/ADC step sweep. It steps the DAC through N_STEPS output codes. For each step it triggers a DAC SPI write, waits a settling interval, triggers an ADC conversion read, then triggers a UART transmit of the result. It sits above the DAC SPI write FSM, the ADC SPI read FSM and the UART TX, and drives their start strobes from their end-of-operation flags.

Parameters:
N_STEPS, 31, number of sweep steps (1..255)
DATA_W, 12, DAC code width
CODE_START, 0, code applied at step 0
CODE_INC, 128, code increment per step
SETTLE_CYC, 1000, clk_i cycles waited after DAC write before ADC read (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  level; sampled in IDLE and DONE, starts a sweep
abort_i  in  1  level; forces return to IDLE at the next edge from any state
dac_eow_i  in  1  DAC writer end-of-write (1 = idle, 0 = busy)
adc_eor_i  in  1  ADC reader end-of-read (1 = idle, 0 = busy)
tx_done_i  in  1  UART TX one-cycle done pulse
dac_strw_o  out  1  one-cycle DAC write start pulse
adc_strr_o  out  1  one-cycle ADC read start pulse
tx_start_o  out  1  one-cycle UART send pulse
dac_code_o  out  DATA_W  code presented to the DAC PISO; stable from DAC_REQ until the next step
step_o  out  8  current step index
busy_o  out  1  high in every state except IDLE and DONE
done_o  out  1  high while in DONE

Behaviour:
- All outputs are registered.
- Reset (rst_i high at a clock edge) gives: state IDLE, all strobes 0, dac_code_o 0, step_o 0, busy_o 0, done_o 0, settle counter 0. The same applies on reset mid-sweep, and any handshake in progress is abandoned.
- IDLE: wait for start_i. On start_i, load step=0 and code=CODE_START, then go to DAC_REQ.
- DAC_REQ: dac_strw_o=1 for exactly one cycle, then go to DAC_WBUSY.
- DAC_WBUSY: wait for dac_eow_i=0, then go to DAC_WDONE. This guards against the writer's idle-high eow.
- DAC_WDONE: wait for dac_eow_i=1. Then clear the settle counter and go to SETTLE.
- SETTLE: count up each cycle. When the count reaches SETTLE_CYC-1, go to ADC_REQ. Time from entering SETTLE to entering ADC_REQ is exactly SETTLE_CYC cycles.
- ADC_REQ: adc_strr_o=1 for one cycle, then go to ADC_WBUSY.
- ADC_WBUSY: wait for adc_eor_i=0, then go to ADC_WDONE.
- ADC_WDONE: wait for adc_eor_i=1, then go to TX_REQ.
- TX_REQ: tx_start_o=1 for one cycle, then go to TX_WAIT.
- TX_WAIT: wait for tx_done_i, then go to NEXT.
- NEXT:
  - if step == N_STEPS-1, go to DONE;
  - else step+1 and code+CODE_INC, then go to DAC_REQ.
- Code arithmetic: computed in DATA_W+1 bits and saturated at 2^DATA_W-1. There is no wrap-around.
- DONE: done_o=1, and dac_code_o holds the last code. start_i restarts from step 0. Holding start_i high therefore sweeps continuously, with exactly one DONE cycle between sweeps.
- abort_i has priority over all transitions except rst_i. It sends the block to IDLE with strobes 0 and step_o/dac_code_o held, not cleared.
- Simultaneous events:
  - start_i is ignored outside IDLE/DONE.
  - tx_done_i is ignored outside TX_WAIT.
  - If tx_done_i arrives in the same cycle as tx_start_o, it is ignored, and the block keeps waiting for a later pulse.
- No timeouts: the block stalls indefinitely if a peripheral never completes.
- Latency from start_i sampled high to dac_strw_o high: 2 cycles (IDLE→DAC_REQ, output registered).

Test Plan:
- N_STEPS=3, CODE_INC=100, SETTLE_CYC=4, peripheral models with 5-cycle busy periods; pulse start_i → exactly 3 dac_strw_o, 3 adc_strr_o and 3 tx_start_o pulses; dac_code_o 0, 100, 200; step_o 0, 1, 2; done_o=1 after the third tx_done_i.
- Settle timing: measure cycles from dac_eow_i rising to adc_strr_o → exactly SETTLE_CYC+1 (state hop plus count), i.e. 5 for SETTLE_CYC=4.
- Saturation: CODE_START=4000, CODE_INC=100, N_STEPS=3 → codes 4000, 4095, 4095.
- Idle-high flag guard: hold dac_eow_i=1 for 10 cycles after dac_strw_o before dropping it → no adc_strr_o until dac_eow_i has gone 0 and back to 1.
- abort_i asserted in SETTLE at step 1 → IDLE next cycle, busy_o=0, step_o=1, no further strobes; rst_i mid-TX_WAIT → all outputs 0 next cycle.
- start_i held high across DONE → second sweep begins; step_o returns to 0 and dac_strw_o fires 2 cycles after leaving DONE.
